// File: rtl/video_timing_counter.sv
// Raster position and timing strobe generator for the HDMI output path.
// Optional macro VTC_RESTART_EN adds a 'restart' input that re-origins the raster to (0,0).
module video_timing_counter #(
  parameter int busWidth       = 12,
  parameter int hActive        = 1920,
  parameter int hFrontPorch    = 88,
  parameter int hSyncWidth     = 44,
  parameter int hBackPorch     = 148,
  parameter int vActive        = 1080,
  parameter int vFrontPorch    = 4,
  parameter int vSyncWidth     = 5,
  parameter int vBackPorch     = 36,
  parameter bit syncActiveHigh = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
`ifdef VTC_RESTART_EN
  input  logic                restart,
`endif
  output logic [busWidth-1:0] hCount,
  output logic [busWidth-1:0] vCount,
  output logic                hSync,
  output logic                vSync,
  output logic                dataEnable,
  output logic                lineStart,
  output logic                frameStart
);

  localparam int HTOTAL = hActive + hFrontPorch + hSyncWidth + hBackPorch;
  localparam int VTOTAL = vActive + vFrontPorch + vSyncWidth + vBackPorch;

  localparam logic [busWidth-1:0] H_ACT_LAST   = busWidth'(hActive - 1);
  localparam logic [busWidth-1:0] H_FRONT_LAST = busWidth'(hActive + hFrontPorch - 1);
  localparam logic [busWidth-1:0] H_SYNC_LAST  = busWidth'(hActive + hFrontPorch + hSyncWidth - 1);
  localparam logic [busWidth-1:0] H_LAST       = busWidth'(HTOTAL - 1);
  localparam logic [busWidth-1:0] V_ACT_LAST   = busWidth'(vActive - 1);
  localparam logic [busWidth-1:0] V_FRONT_LAST = busWidth'(vActive + vFrontPorch - 1);
  localparam logic [busWidth-1:0] V_SYNC_LAST  = busWidth'(vActive + vFrontPorch + vSyncWidth - 1);
  localparam logic [busWidth-1:0] V_LAST       = busWidth'(VTOTAL - 1);
  localparam logic [busWidth-1:0] COUNT_ONE    = busWidth'(1);
  localparam logic                SYNC_IDLE    = !syncActiveHigh;

  // Zero-length regions would collapse FSM transitions onto each other.
  if (hActive < 1 || hFrontPorch < 1 || hSyncWidth < 1 || hBackPorch < 1 ||
      vActive < 1 || vFrontPorch < 1 || vSyncWidth < 1 || vBackPorch < 1) begin : gBadTiming
    $error("video_timing_counter: active, porch and sync parameters must all be nonzero");
  end
  if (HTOTAL - 1 >= (1 << busWidth) || VTOTAL - 1 >= (1 << busWidth)) begin : gBadWidth
    $error("video_timing_counter: busWidth too small for HTOTAL/VTOTAL");
  end

  typedef enum logic [2:0] {PRIMING, H_ACTIVE, H_FRONT, H_SYNC, H_BACK} hStateT;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} vStateT;

  hStateT              hState, hStateNext;
  vStateT              vState, vStateNext;
  logic [busWidth-1:0] hCountNext, vCountNext;
  logic                goOrigin;

  always_ff @(posedge clock) begin
    if (reset) begin
      hState     <= PRIMING;
      vState     <= V_ACTIVE;
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= SYNC_IDLE;
      vSync      <= SYNC_IDLE;
      dataEnable <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (enable) begin
      hState     <= hStateNext;
      vState     <= vStateNext;
      hCount     <= hCountNext;
      vCount     <= vCountNext;
      hSync      <= (hStateNext == H_SYNC) ? syncActiveHigh : SYNC_IDLE;
      vSync      <= (vStateNext == V_SYNC) ? syncActiveHigh : SYNC_IDLE;
      dataEnable <= (hStateNext == H_ACTIVE) && (vStateNext == V_ACTIVE);
      lineStart  <= (hCountNext == '0);
      frameStart <= (hCountNext == '0) && (vCountNext == '0);
    end
  end

  // Strobes are registered from the next position so they never skew from the counts.
  always_comb begin
    hStateNext = hState;
    vStateNext = vState;
    hCountNext = hCount;
    vCountNext = vCount;
    goOrigin   = (hState == PRIMING);
`ifdef VTC_RESTART_EN
    goOrigin   = goOrigin || restart;
`endif
    if (goOrigin) begin
      hStateNext = H_ACTIVE;
      vStateNext = V_ACTIVE;
      hCountNext = '0;
      vCountNext = '0;
    end else if (hCount == H_LAST) begin
      hStateNext = H_ACTIVE;
      hCountNext = '0;
      if (vCount == V_LAST) begin
        vStateNext = V_ACTIVE;
        vCountNext = '0;
      end else begin
        vCountNext = vCount + COUNT_ONE;
        case (vState)
          V_ACTIVE: if (vCount == V_ACT_LAST)   vStateNext = V_FRONT;
          V_FRONT:  if (vCount == V_FRONT_LAST) vStateNext = V_SYNC;
          V_SYNC:   if (vCount == V_SYNC_LAST)  vStateNext = V_BACK;
          default:  vStateNext = vState;
        endcase
      end
    end else begin
      hCountNext = hCount + COUNT_ONE;
      case (hState)
        H_ACTIVE: if (hCount == H_ACT_LAST)   hStateNext = H_FRONT;
        H_FRONT:  if (hCount == H_FRONT_LAST) hStateNext = H_SYNC;
        H_SYNC:   if (hCount == H_SYNC_LAST)  hStateNext = H_BACK;
        default:  hStateNext = hState;
      endcase
    end
  end

endmodule

// File: tb/tb_video_timing_counter.sv
// Self-checking bench for video_timing_counter on a small 14x8 raster.
// Runs a high-level position model alongside two DUTs (sync active high and active low).
module tb_video_timing_counter;

  localparam int BW = 4;
  localparam int HA = 8, HF = 2, HS = 3, HB = 1;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          restart = 1'b0;
  logic [BW-1:0] hCount, vCount, hCountL, vCountL;
  logic          hSync, vSync, dataEnable, lineStart, frameStart;
  logic          hSyncL, vSyncL, dataEnableL, lineStartL, frameStartL;

  int assertCount = 0;
  int failCount   = 0;
  bit checkOn     = 1'b0;

  int mh = 0;
  int mv = 0;
  bit primed = 1'b0;

  logic [13:0] deTable = 14'b00000011111111;
  logic [13:0] hsTable = 14'b01110000000000;

  video_timing_counter #(
    .busWidth(BW), .hActive(HA), .hFrontPorch(HF), .hSyncWidth(HS), .hBackPorch(HB),
    .vActive(VA), .vFrontPorch(VF), .vSyncWidth(VS), .vBackPorch(VB), .syncActiveHigh(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
`ifdef VTC_RESTART_EN
    .restart(restart),
`endif
    .hCount(hCount), .vCount(vCount), .hSync(hSync), .vSync(vSync),
    .dataEnable(dataEnable), .lineStart(lineStart), .frameStart(frameStart)
  );

  video_timing_counter #(
    .busWidth(BW), .hActive(HA), .hFrontPorch(HF), .hSyncWidth(HS), .hBackPorch(HB),
    .vActive(VA), .vFrontPorch(VF), .vSyncWidth(VS), .vBackPorch(VB), .syncActiveHigh(1'b0)
  ) dutLow (
    .clock(clock), .reset(reset), .enable(enable),
`ifdef VTC_RESTART_EN
    .restart(restart),
`endif
    .hCount(hCountL), .vCount(vCountL), .hSync(hSyncL), .vSync(vSyncL),
    .dataEnable(dataEnableL), .lineStart(lineStartL), .frameStart(frameStartL)
  );

  always #5 clock = ~clock;

  // Position model: a primed raster simply counts pixels modulo the frame size.
  always @(posedge clock) begin
    if (reset) begin
      primed = 1'b0;
      mh = 0;
      mv = 0;
    end else if (enable) begin
      if (!primed || restart) begin
        primed = 1'b1;
        mh = 0;
        mv = 0;
      end else begin
        mh = mh + 1;
        if (mh == HT) begin
          mh = 0;
          mv = (mv + 1) % VT;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic s);
    reset   = r;
    enable  = e;
    restart = s;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Compare both DUTs with the model on every cycle once reset has been sampled.
  always @(negedge clock) begin
    if (checkOn) begin
      logic expDe, expHs, expVs, expLs, expFs;
      expDe = primed && (mh < HA) && (mv < VA);
      expHs = primed && (mh >= HA + HF) && (mh < HA + HF + HS);
      expVs = primed && (mv >= VA + VF) && (mv < VA + VF + VS);
      expLs = primed && (mh == 0);
      expFs = primed && (mh == 0) && (mv == 0);
      checkOutput("cyc.hCount", 32'(hCount), 32'(mh));
      checkOutput("cyc.vCount", 32'(vCount), 32'(mv));
      checkOutput("cyc.hSync", 32'(hSync), 32'(expHs));
      checkOutput("cyc.vSync", 32'(vSync), 32'(expVs));
      checkOutput("cyc.dataEnable", 32'(dataEnable), 32'(expDe));
      checkOutput("cyc.lineStart", 32'(lineStart), 32'(expLs));
      checkOutput("cyc.frameStart", 32'(frameStart), 32'(expFs));
      checkOutput("cycLow.hCount", 32'(hCountL), 32'(mh));
      checkOutput("cycLow.vCount", 32'(vCountL), 32'(mv));
      checkOutput("cycLow.hSync", 32'(hSyncL), 32'(!expHs));
      checkOutput("cycLow.vSync", 32'(vSyncL), 32'(!expVs));
      checkOutput("cycLow.dataEnable", 32'(dataEnableL), 32'(expDe));
      checkOutput("cycLow.frameStart", 32'(frameStartL), 32'(expFs));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vsHigh;
    int enabledCount;
    int pos;
    bit found;
    checkOn = 1'b1;

    // Reset state, including with enable low
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst.hCount", 32'(hCount), 0);
    checkOutput("rst.vCount", 32'(vCount), 0);
    checkOutput("rst.dataEnable", 32'(dataEnable), 0);
    checkOutput("rst.frameStart", 32'(frameStart), 0);
    checkOutput("rst.lineStart", 32'(lineStart), 0);
    checkOutput("rst.hSync", 32'(hSync), 0);
    checkOutput("rst.vSync", 32'(vSync), 0);
    checkOutput("rstLow.hSync", 32'(hSyncL), 1);
    checkOutput("rstLow.vSync", 32'(vSyncL), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle.dataEnable", 32'(dataEnable), 0);
    checkOutput("idle.frameStart", 32'(frameStart), 0);

    // Priming edge presents (0,0) without incrementing
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("prime.hCount", 32'(hCount), 0);
    checkOutput("prime.vCount", 32'(vCount), 0);
    checkOutput("prime.frameStart", 32'(frameStart), 1);
    checkOutput("prime.lineStart", 32'(lineStart), 1);
    checkOutput("prime.dataEnable", 32'(dataEnable), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("second.hCount", 32'(hCount), 1);
    checkOutput("second.frameStart", 32'(frameStart), 0);

    // First line
    for (int i = 2; i < 14; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("line.hCount", 32'(hCount), 32'(i));
      checkOutput("line.dataEnable", 32'(dataEnable), 32'(deTable[i]));
      checkOutput("line.hSync", 32'(hSync), 32'(hsTable[i]));
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("line2.hCount", 32'(hCount), 0);
    checkOutput("line2.vCount", 32'(vCount), 1);
    checkOutput("line2.lineStart", 32'(lineStart), 1);
    checkOutput("line2.frameStart", 32'(frameStart), 0);

    // Rest of the frame and wrap back to the origin
    vsHigh = 0;
    for (int i = 0; i < 98; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (vSync) vsHigh++;
      if (i == 96) begin
        checkOutput("frameEnd.hCount", 32'(hCount), 13);
        checkOutput("frameEnd.vCount", 32'(vCount), 7);
      end
    end
    checkOutput("frame.vSyncCycles", 32'(vsHigh), 28);
    checkOutput("wrap.hCount", 32'(hCount), 0);
    checkOutput("wrap.vCount", 32'(vCount), 0);
    checkOutput("wrap.frameStart", 32'(frameStart), 1);

    // Random enable gaps: position depends only on the number of enabled edges
    enabledCount = 0;
    for (int i = 0; i < 300; i++) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, e, 1'b0);
      if (e) enabledCount++;
    end
    pos = enabledCount % (HT * VT);
    checkOutput("gaps.hCount", 32'(hCount), 32'(pos % HT));
    checkOutput("gaps.vCount", 32'(vCount), 32'(pos / HT));

    // Mid-frame reset at (11,5)
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (hCount == 11 && vCount == 5) found = 1'b1;
      else applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("reach(11,5)", 32'(found), 1);
    checkOutput("mid.hSync", 32'(hSync), 1);
    checkOutput("mid.vSync", 32'(vSync), 1);
    checkOutput("midLow.hSync", 32'(hSyncL), 0);
    checkOutput("midLow.vSync", 32'(vSyncL), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("midRst.hCount", 32'(hCount), 0);
    checkOutput("midRst.vCount", 32'(vCount), 0);
    checkOutput("midRst.hSync", 32'(hSync), 0);
    checkOutput("midRst.vSync", 32'(vSync), 0);
    checkOutput("midRst.dataEnable", 32'(dataEnable), 0);
    checkOutput("midRstLow.hSync", 32'(hSyncL), 1);
    checkOutput("midRstLow.vSync", 32'(vSyncL), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reprime.frameStart", 32'(frameStart), 1);
    checkOutput("reprime.dataEnable", 32'(dataEnable), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reprime.hCount", 32'(hCount), 1);

`ifdef VTC_RESTART_EN
    // Restart at (9,2) re-origins the raster; reset still dominates
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (hCount == 9 && vCount == 2) found = 1'b1;
      else applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("reach(9,2)", 32'(found), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("restart.hCount", 32'(hCount), 0);
    checkOutput("restart.vCount", 32'(vCount), 0);
    checkOutput("restart.frameStart", 32'(frameStart), 1);
    checkOutput("restart.dataEnable", 32'(dataEnable), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("restartHeld.hCount", 32'(hCount), 3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("restartRst.hCount", 32'(hCount), 0);
    checkOutput("restartRst.dataEnable", 32'(dataEnable), 0);
    checkOutput("restartRst.frameStart", 32'(frameStart), 0);
    checkOutput("restartRst.hSync", 32'(hSync), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restartPrime.frameStart", 32'(frameStart), 1);
`endif

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
